peripheral_bfm_master_generic_bb: RTL and testbench
===================================================

// Module: peripheral_bfm_master_generic_bb
// PURPOSE
//  AXI initiator BFM for bb benches. Takes one command at a time on a valid/ready port.
//  Drives the AXI write channels (AW/W/B) or read channels (AR/R) toward a slave DUT or slave BFM.
//  Returns one result per completed beat on a response port.
// PARAMETERS
//  AXI_ID          4'h0  constant driven on awid/wid/arid
//  TIMEOUT_CYCLES  256   per-state wait limit (used only with PERIPHERAL_BFM_TIMEOUT_EN)
// PORTS
//  aclk        in   1   clock
//  aresetn     in   1   reset, synchronous, active-low
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   high only in IDLE
//  cmd_write   in   1   1=write, 0=read
//  cmd_addr    in   32  byte address, driven unmodified
//  cmd_len     in   4   read beats-1; ignored for writes (always 1 beat)
//  cmd_wdata   in   32  write data
//  cmd_wstrb   in   4   write strobes
//  rsp_valid   out  1   1-cycle pulse per result
//  rsp_data    out  32  read beat data; 0 for writes
//  rsp_resp    out  2   bresp/rresp; 2'b11 on timeout
//  rsp_last    out  1   final result of the command
//  awid/awadr/awlen/awsize/abburst/awlock/awcache/awprot  out  4/32/4/3/2/2/4/3  AW payload
//  awvalid out 1; awready in 1                       AW handshake
//  wid/wrdata/wstrb/wlast  out  4/32/4/1             W payload
//  wvalid out 1; wready in 1                         W handshake
//  bid in 4; bresp in 2; bvalid in 1; bready out 1   B channel
//  arid/araddr/arlen/arsize/arlock/arcache/arprot  out  4/32/4/3/2/4/3  AR payload
//  arvalid out 1; arready in 1                       AR handshake
//  rid in 4; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1  R channel
// BEHAVIOUR
//  Reset: all valids 0; bready, rready 0; rsp_* 0; payload regs 0; state IDLE (cmd_ready=1).
//  FSM states: IDLE, WRITE, WRESP, RADDR, RDATA. All outputs registered.
//  IDLE: on cmd_valid, latch the command.
//   cmd_write=1 -> WRITE; cmd_write=0 -> RADDR.
//  WRITE: awvalid and wvalid rise together in the cycle after acceptance.
//   Each valid drops independently on its own ready. Payload is held stable while valid.
//   Go to WRESP when both handshakes are done; same-cycle handshakes are allowed.
//  WRESP: bready=1. On bvalid: rsp_valid=1, rsp_resp=bresp, rsp_last=1; go to IDLE.
//  RADDR: arvalid=1, arlen=cmd_len, held until arready; then go to RDATA.
//  RDATA: rready=1. Each rvalid beat produces rsp_valid=1, rsp_data=rdata, rsp_resp=rresp.
//   The 4-bit beat counter then increments.
//  Read termination: the beat where rlast=1 or counter==arlen sets rsp_last=1, rready=0, and goes to IDLE.
//   Early rlast also ends the command.
//  Response latency: rsp appears 1 cycle after the B/R handshake.
//  Back-to-back: next cmd accepted the cycle after returning to IDLE.
//  Fixed attributes: awsize=arsize=3'b010; abburst=INCR; lock/cache/prot=0; awlen=0; wlast=1.
//  cmd_valid outside IDLE is ignored (cmd_ready=0).
//  aresetn low mid-transaction: IDLE next edge, all valids/readies 0, no rsp emitted.
//  bid/rid are not checked.
// CONFIGURATION
//  PERIPHERAL_BFM_TIMEOUT_EN defined:
//   16-bit wait counter, cleared on every state change and on every handshake.
//   When it reaches TIMEOUT_CYCLES in any non-IDLE state:
//   all valids/readies drop; rsp_valid=1, rsp_resp=2'b11, rsp_last=1, rsp_data=0; go to IDLE.
//  Undefined: no counter; the BFM waits indefinitely.
// STRUCTURE
//  peripheral_bb_verilog_pkg holds:
//   AXI_RESPONSE_OKAY/EXOKAY/SLVERR/DECERR, AXI_BURST_INCR, AXI_SIZE_WORD,
//   typedef enum logic [2:0] bfm_master_state_t.
//  Single module; no sub-module needed.
// TESTING
//  Write 0x10 data 0xDEADBEEF strb 4'hF, then read 0x10 len 0 against slave BFM:
//   write rsp resp 2'b00, last 1; read rsp data 0xDEADBEEF, last 1.
//  Read 0x20 len 3, responder returns 0xA0..0xA3 with rlast on beat 4:
//   4 rsp pulses in order; rsp_last only on 0xA3.
//  awready delayed 3 cycles, wready immediate: awvalid held 3 cycles, wvalid 1 cycle, exactly 1 rsp.
//  Responder returns bresp=2'b10: rsp_resp=2'b10, rsp_last=1; cmd_ready=1 on the next cycle.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, arready tied 0:
//   arvalid drops after 8 cycles; rsp_resp=2'b11, rsp_last=1.
//  aresetn low during beat 2 of a len-3 read: all valids/readies 0 next cycle, cmd_ready=1, no rsp.

Source files
------------

// File: rtl/peripheral_bb_verilog_pkg.sv
// Shared AXI constants and the BFM master state type for the bb bench slice.
package peripheral_bb_verilog_pkg;

  localparam logic [1:0] AXI_RESPONSE_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESPONSE_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESPONSE_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESPONSE_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } bfm_master_state_t;

endpackage

// File: rtl/peripheral_bfm_master_generic_bb.sv
// AXI initiator BFM: one command at a time, single-beat writes or (len+1)-beat reads.
// Define PERIPHERAL_BFM_TIMEOUT_EN to abort any wait longer than TIMEOUT_CYCLES with resp 2'b11.
module peripheral_bfm_master_generic_bb
  import peripheral_bb_verilog_pkg::*;
#(
  parameter logic [3:0] AXI_ID         = 4'h0,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        rsp_last,
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  abburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising aclk edge where valid and ready are both 1;
  // a valid, once raised, stays high with its payload frozen until that edge.

  bfm_master_state_t state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        rsp_last_q, rsp_last_d;
  logic        progress;

`ifdef PERIPHERAL_BFM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT_CYCLES);
`endif

  logic [7:0] id_unused;
  assign id_unused = {bid, rid};

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    len_d       = len_q;
    beat_d      = beat_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 32'd0;
    rsp_resp_d  = AXI_RESPONSE_OKAY;
    rsp_last_d  = 1'b0;
    progress    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          len_d       = cmd_len;
          beat_d      = 4'd0;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          progress  = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          progress = 1'b1;
        end
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bvalid) begin
          progress    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bresp;
          rsp_last_d  = 1'b1;
          bready_d    = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (arready) begin
          progress  = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = 4'd0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid) begin
          progress    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rdata;
          rsp_resp_d  = rresp;
          beat_d      = beat_q + 4'd1;
          // An early rlast from the slave ends the command just like the final counted beat.
          if (rlast || (beat_q == len_q)) begin
            rsp_last_d  = 1'b1;
            rready_d    = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

`ifdef PERIPHERAL_BFM_TIMEOUT_EN
    wait_d = 16'd0;
    if (state_q != ST_IDLE && !progress) begin
      if (wait_q == TIMEOUT_LAST) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 32'd0;
        rsp_resp_d  = AXI_RESPONSE_DECERR;
        rsp_last_d  = 1'b1;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        wait_d = wait_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_resp_q  <= 2'b00;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

`ifdef PERIPHERAL_BFM_TIMEOUT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) wait_q <= 16'd0;
    else          wait_q <= wait_d;
  end
`endif

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_last    = rsp_last_q;
  assign dbg_state_o = state_q;

  assign awid    = AXI_ID;
  assign awadr   = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = AXI_SIZE_WORD;
  assign abburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid    = AXI_ID;
  assign wrdata = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = bready_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = AXI_SIZE_WORD;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule

// File: tb/tb_peripheral_bfm_master_generic_bb.sv
// Directed bench for the AXI master BFM: inline slave responder, word memory model, response scoreboard.
module tb_peripheral_bfm_master_generic_bb;
  import peripheral_bb_verilog_pkg::*;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_len, cmd_wstrb;
  logic        rsp_valid, rsp_last;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [3:0]  awid, awlen, awcache, wid, wstrb, arid, arlen, arcache;
  logic [31:0] awadr, wrdata, araddr, rdata;
  logic [2:0]  awsize, awprot, arsize, arprot, dbg_state;
  logic [1:0]  abburst, awlock, arlock, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  bid, rid;

  peripheral_bfm_master_generic_bb #(.AXI_ID(4'h0), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .abburst(abburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: {data, resp, last} per expected result, in order
  localparam int W = 35;
  logic [W-1:0] exp_q[$];
  logic [31:0]  mem [logic [31:0]];
  logic [31:0]  rd_data [16];
  logic [1:0]   rd_resp [16];

  always @(negedge aclk) begin
    if (cmp_en) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%0h required=no_result", {rsp_data, rsp_resp, rsp_last});
        end else begin
          check("rsp", {29'd0, rsp_data, rsp_resp, rsp_last}, {29'd0, exp_q.pop_front()});
        end
      end
      if (awvalid)
        check("aw_fixed", {awid, awlen, awsize, abburst, awlock, awcache, awprot},
              {4'h0, 4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0});
      if (wvalid) check("w_fixed", {wid, wlast}, {4'h0, 1'b1});
      if (arvalid)
        check("ar_fixed", {arid, arsize, arlock, arcache, arprot}, {4'h0, 3'b010, 2'b00, 4'h0, 3'h0});
    end
  end

  // Driver tasks
  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                       input logic [31:0] wd, input logic [3:0] ws);
    int n;
    n = 0;
    @(negedge aclk);
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    cmd_wdata = wd; cmd_wstrb = ws;
  endtask

  // While busy, cmd_valid stays high with junk fields: it must be ignored.
  task automatic scramble();
    cmd_write = ~cmd_write; cmd_addr = ~cmd_addr; cmd_len = ~cmd_len;
    cmd_wdata = ~cmd_wdata; cmd_wstrb = ~cmd_wstrb;
  endtask

  task automatic drain();
    slave_idle();
    cmd_valid = 1'b0;
    @(negedge aclk);
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int aw_hold, input int w_hold, input logic [1:0] br);
    int aw_hi, w_hi, cyc;
    bit b_sent, prev_hs, done;
    logic [31:0] word;
    aw_hi = 0; w_hi = 0; cyc = 0; b_sent = 0; prev_hs = 0; done = 0;
    word = mem.exists(addr) ? mem[addr] : 32'd0;
    for (int b = 0; b < 4; b++) if (ws[b]) word[8*b +: 8] = wd[8*b +: 8];
    mem[addr] = word;
    exp_q.push_back({32'd0, br, 1'b1});
    issue(1'b1, addr, 4'd0, wd, ws);
    while (!done && cyc < 200) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        check("wr_cmd_busy", cmd_ready, 0);
        check("aw_w_rise", {awvalid, wvalid}, 2'b11);
        scramble();
      end
      check("b_rsp_latency", rsp_valid, prev_hs);
      prev_hs = 1'b0;
      slave_idle();
      if (cmd_ready && cyc > 1) begin
        done = 1'b1;
      end else begin
        if (awvalid) begin
          aw_hi++;
          check("aw_payload", awadr, addr);
          if (aw_hi >= aw_hold) awready = 1'b1;
        end
        if (wvalid) begin
          w_hi++;
          check("w_payload", {wrdata, wstrb}, {wd, ws});
          if (w_hi >= w_hold) wready = 1'b1;
        end
        if (bready && !b_sent) begin
          bvalid = 1'b1; bresp = br; b_sent = 1'b1; prev_hs = 1'b1;
        end
      end
    end
    check("write_done", done, 1);
    check("aw_cycles", aw_hi, aw_hold);
    check("w_cycles", w_hi, w_hold);
    drain();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input int rlast_at,
                         input int ar_hold, input bit gaps, input int rst_beat, input bit exp_to);
    int n, n_exp, beat, ar_hi, cyc;
    bit prev_hs, done;
    beat = 0; ar_hi = 0; cyc = 0; prev_hs = 0; done = 0;
    n = (rlast_at <= int'(len)) ? rlast_at + 1 : int'(len) + 1;
    n_exp = exp_to ? 0 : ((rst_beat >= 0) ? rst_beat : n);
    for (int i = 0; i < n_exp; i++)
      exp_q.push_back({rd_data[i], rd_resp[i], (i == n_exp - 1) && (rst_beat < 0)});
    if (exp_to) exp_q.push_back({32'd0, 2'b11, 1'b1});
    issue(1'b0, addr, len, 32'd0, 4'd0);
    while (!done && cyc < 300) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        check("rd_cmd_busy", cmd_ready, 0);
        check("ar_rise", arvalid, 1);
        scramble();
      end
      check("r_rsp_latency", rsp_valid, prev_hs || (exp_to && cmd_ready && cyc > 1));
      prev_hs = 1'b0;
      slave_idle();
      if (cmd_ready && cyc > 1) begin
        done = 1'b1;
      end else begin
        if (arvalid) begin
          ar_hi++;
          check("ar_payload", {araddr, arlen}, {addr, len});
          if (ar_hi >= ar_hold) arready = 1'b1;
        end
        if (rready && beat < 16 && !(gaps && (cyc % 2 == 1))) begin
          rvalid = 1'b1; rdata = rd_data[beat]; rresp = rd_resp[beat];
          rlast = (beat == rlast_at);
          if (beat == rst_beat) aresetn = 1'b0;
          else prev_hs = 1'b1;
          beat++;
        end
      end
    end
    check("read_done", done, 1);
    if (rst_beat >= 0) begin
      check("rst_beats", beat, rst_beat + 1);
      check("rst_quiet", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 7'b0000001);
      aresetn = 1'b1;
    end else if (exp_to) begin
      check("ar_timeout_cycles", ar_hi, 8);
      check("rready_after_timeout", rready, 0);
    end else begin
      check("r_beats", beat, n);
      check("ar_cycles", ar_hi, ar_hold);
    end
    drain();
  endtask

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 4'd0;
    cmd_wdata = 32'd0; cmd_wstrb = 4'd0; bid = 4'h5; rid = 4'hA; bresp = 2'b00;
    rresp = 2'b00; rdata = 32'd0;
    slave_idle();
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("rst_rsp", {rsp_valid, rsp_data, rsp_resp, rsp_last}, 36'd0);
    check("rst_payload", {awadr, wrdata, wstrb, araddr, arlen}, 104'd0);
    check("rst_state_idle", dbg_state, ST_IDLE);
    aresetn = 1'b1;
    cmp_en = 1'b1;

    // Write then read back through the memory model
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 2'b00);
    check("mem_pin_deadbeef", mem[32'h10], 32'hDEADBEEF);
    rd_data[0] = mem[32'h10]; rd_resp[0] = 2'b00;
    do_read(32'h10, 4'd0, 0, 1, 1'b0, -1, 1'b0);

    // Four-beat read ending on rlast, slave inserting gaps
    for (int i = 0; i < 4; i++) begin rd_data[i] = 32'hA0 + i; rd_resp[i] = 2'b00; end
    do_read(32'h20, 4'd3, 3, 1, 1'b1, -1, 1'b0);

    // Independent AW/W drop, error response, same-cycle handshakes
    do_write(32'h30, 32'h12345678, 4'hF, 3, 1, 2'b00);
    do_write(32'h10, 32'h11223344, 4'b0101, 1, 4, 2'b10);
    check("mem_pin_strb", mem[32'h10], 32'hDE22BE44);
    do_write(32'h40, 32'hCAFE0001, 4'hF, 2, 2, 2'b01);

    // Early rlast, counter termination, maximum length
    for (int i = 0; i < 16; i++) begin rd_data[i] = 32'h5A00_0000 ^ (i * 32'h0101_0101); rd_resp[i] = 2'(i); end
    do_read(32'h50, 4'd5, 2, 2, 1'b0, -1, 1'b0);
    do_read(32'h60, 4'd1, 99, 1, 1'b1, -1, 1'b0);
    for (int i = 0; i < 16; i++) begin rd_data[i] = 32'hB000_0000 + i; rd_resp[i] = 2'b00; end
    do_read(32'h70, 4'd15, 99, 1, 1'b0, -1, 1'b0);

    // Reset during beat 2 of a len-3 read, then straight back to work
    do_read(32'h80, 4'd3, 3, 1, 1'b0, 1, 1'b0);
    do_write(32'h90, 32'h0BADF00D, 4'hF, 1, 1, 2'b11);

`ifdef PERIPHERAL_BFM_TIMEOUT_EN
    do_read(32'hA0, 4'd2, 99, 1000, 1'b0, -1, 1'b1);
`endif

    repeat (2) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
